barrel_shift_seq: RTL



---
 rtl/barrel_shift_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/barrel_shift_seq.sv
// barrel_shift_seq -- iterative shift controller built from single-step barrel stages.
//
// A request (din, shamt, LR, arith) is accepted over a valid/ready handshake.
// The operand is then shifted one stage-step per cycle until shamt is consumed.
// The result is offered over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when high (IDLE only)
//   din        operand, DWIDTH bits
//   shamt      shift amount, 0..DWIDTH-1
//   LR         1 = left, 0 = right
//   arith      right shifts only: 1 = sign-fill, 0 = zero-fill
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   dout       result (always mirrors the working register)
//   busy       high while a transaction is in flight (SHIFT or DONE)
//
// Optional build macro: BARREL_SHIFT_SEQ_FAST4_EN
//   Adds a step-4 stage. Remaining counts >= 4 consume four positions per cycle.
//   Results are identical to the default build; only latency shrinks.

// Single barrel stage: shifts din by STEP_SIZE when shamt is set, else passes it through.
// Left shifts zero-fill. Right shifts fill with sign_bit.
module barrel #(
    parameter int DWIDTH    = 8,
    parameter int STEP_SIZE = 1
) (
    input  logic [DWIDTH-1:0] din,
    input  logic              LR,
    input  logic              shamt,
    input  logic              sign_bit,
    output logic [DWIDTH-1:0] dout
);
    logic [DWIDTH-1:0] shl;
    logic [DWIDTH-1:0] shr;

    generate
        if (STEP_SIZE >= DWIDTH) begin : g_full
            // A step that spans the whole word leaves only fill bits.
            assign shl = '0;
            assign shr = {DWIDTH{sign_bit}};
        end else begin : g_part
            assign shl = {din[DWIDTH-1-STEP_SIZE:0], {STEP_SIZE{1'b0}}};
            assign shr = {{STEP_SIZE{sign_bit}}, din[DWIDTH-1:STEP_SIZE]};
        end
    endgenerate

    assign dout = !shamt ? din : (LR ? shl : shr);
endmodule

module barrel_shift_seq #(
    parameter int DWIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DWIDTH-1:0]         din,
    input  logic [$clog2(DWIDTH)-1:0] shamt,
    input  logic                      LR,
    input  logic                      arith,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DWIDTH-1:0]         dout,
    output logic                      busy
);
    localparam int SAW = $clog2(DWIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state_q;
    logic [DWIDTH-1:0] data_q;
    logic [SAW-1:0]    cnt_q;
    logic              lr_q;
    logic              arith_q;

    logic              sign_bit;
    logic [DWIDTH-1:0] step1;
    logic [DWIDTH-1:0] data_nxt;
    logic [SAW-1:0]    cnt_nxt;

    // The operand MSB is re-fed every step.
    // An arithmetic right shift therefore keeps replicating the original sign.
    assign sign_bit = arith_q & ~lr_q & data_q[DWIDTH-1];

    barrel #(.DWIDTH(DWIDTH), .STEP_SIZE(1)) u_step1 (
        .din      (data_q),
        .LR       (lr_q),
        .shamt    (1'b1),
        .sign_bit (sign_bit),
        .dout     (step1)
    );

`ifdef BARREL_SHIFT_SEQ_FAST4_EN
    logic [DWIDTH-1:0] step4;
    logic              use4;

    barrel #(.DWIDTH(DWIDTH), .STEP_SIZE(4)) u_step4 (
        .din      (data_q),
        .LR       (lr_q),
        .shamt    (1'b1),
        .sign_bit (sign_bit),
        .dout     (step4)
    );

    // Widen by one bit so the constant 3 is representable even when SAW < 3.
    assign use4     = ({1'b0, cnt_q} > (SAW+1)'(3));
    assign data_nxt = use4 ? step4 : step1;
    assign cnt_nxt  = use4 ? (cnt_q - SAW'(4)) : (cnt_q - SAW'(1));
`else
    assign data_nxt = step1;
    assign cnt_nxt  = cnt_q - SAW'(1);
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dout      = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            lr_q    <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= din;
                        cnt_q   <= shamt;
                        lr_q    <= LR;
                        arith_q <= arith;
                        state_q <= (shamt != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    // The last step lands on the same edge that enters DONE.
                    data_q <= data_nxt;
                    cnt_q  <= cnt_nxt;
                    if (cnt_nxt == '0) state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
